seq_div: RTL

Iterative unsigned restoring divider. It is the inverse of the team's combinational multiplier: it computes quotient and remainder of two DATAWIDTH-bit operands, one quotient bit per clock. It sits beside the multiplier in the datapath library and is used wherever a division is scheduled. A start/done handshake lets a controller FSM launch an operation and wait for the result.

---
 rtl/seq_div.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seq_div.sv
// rtl/seq_div.sv - iterative unsigned restoring divider, one quotient bit per clock
//
// Purpose:
//   Computes quot = floor(a / b) and rem = a mod b for DATAWIDTH-bit unsigned
//   operands using a restoring shift/subtract loop. One quotient bit is
//   produced per clock, so a division takes DATAWIDTH cycles from the start
//   edge to the done pulse. Division by zero is not special-cased: the loop
//   naturally yields quot = all ones and rem = a.
//
// Optional feature:
//   SEQ_DIV_DBZ_EN - when defined, adds the dbz output, which reports whether
//                    the captured divisor was zero for the most recent result.
//
// Ports:
//   clk    in   1          rising-edge clock
//   rst    in   1          asynchronous, active-high reset
//   start  in   1          launch request, accepted in IDLE or DONE
//   a      in   DATAWIDTH  dividend, captured when start is accepted
//   b      in   DATAWIDTH  divisor, captured when start is accepted
//   busy   out  1          high while a division is in progress
//   done   out  1          single-cycle pulse, quot/rem just became valid
//   dbz    out  1          divide-by-zero flag (SEQ_DIV_DBZ_EN only)
//   quot   out  DATAWIDTH  registered quotient, holds until next completion
//   rem    out  DATAWIDTH  registered remainder, holds until next completion

module seq_div #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
`ifdef SEQ_DIV_DBZ_EN
  output logic                 dbz,
`endif
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(DATAWIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;

  // dvd_q starts as the dividend; each iteration its top bit moves into the
  // partial remainder and the new quotient bit enters at the bottom, so after
  // DATAWIDTH iterations it holds the quotient.
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  quot_d, rem_d;
  logic          busy_d, done_d;
`ifdef SEQ_DIV_DBZ_EN
  logic          dbz_d;
`endif

  // Iteration datapath. shifted is the DATAWIDTH+1-bit partial remainder
  // after the left shift. The stored remainder is always < divisor, so it
  // fits in DATAWIDTH bits; only the shifted value needs the extra bit.
  logic [W:0]    shifted;
  logic          qbit;
  logic [W-1:0]  diff_lo;
  logic [W-1:0]  prem_next;
  logic [W-1:0]  dvd_next;

  assign shifted   = {prem_q, dvd_q[W-1]};
  assign qbit      = (shifted >= {1'b0, dvs_q});
  // When the trial subtraction succeeds the difference is < divisor, so the
  // low DATAWIDTH bits of the modular difference are the exact result.
  assign diff_lo   = shifted[W-1:0] - dvs_q;
  // On restore, shifted < divisor, so its top bit is zero and can be dropped.
  assign prem_next = qbit ? diff_lo : shifted[W-1:0];
  assign dvd_next  = {dvd_q[W-2:0], qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot;
    rem_d   = rem;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SEQ_DIV_DBZ_EN
    dbz_d   = dbz;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          prem_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        // start is deliberately not looked at here: a running operation
        // can neither be restarted nor have its operands replaced.
        dvd_d  = dvd_next;
        prem_d = prem_next;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          // Results are loaded straight from the final iteration so that
          // quot/rem never expose partial values.
          quot_d  = dvd_next;
          rem_d   = prem_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SEQ_DIV_DBZ_EN
          dbz_d   = (dvs_q == '0);
`endif
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
      quot   <= '0;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SEQ_DIV_DBZ_EN
      dbz    <= 1'b0;
`endif
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      cnt_q  <= cnt_d;
      quot   <= quot_d;
      rem    <= rem_d;
      busy   <= busy_d;
      done   <= done_d;
`ifdef SEQ_DIV_DBZ_EN
      dbz    <= dbz_d;
`endif
    end
  end

endmodule
